// File: rtl/distribute_pkg.sv
// Shared types and constants for the one-hot distributor.
// The perf counter width is used only when DISTRIBUTE_PERF_CNT_EN is set.
package distribute_pkg;

   localparam int PERF_CNT_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } dist_state_e;

endpackage

// File: rtl/distribute_out_slot.sv
// One output port: pending bit, data gating and an optional delivery counter.
// DISTRIBUTE_PERF_CNT_EN adds the saturating o_perf_cnt output.
module distribute_out_slot
   import distribute_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  load_bit,
   input  logic                  i_ready,
   input  logic [DATA_WIDTH-1:0] data_r,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
`ifdef DISTRIBUTE_PERF_CNT_EN
   ,
   output logic [PERF_CNT_WIDTH-1:0] o_perf_cnt
`endif
);

   logic pending_r;
   logic fire;

   assign fire    = pending_r && i_ready;
   assign o_valid = pending_r;
   assign o_data  = pending_r ? data_r : '0;

   // load wins over drain: the top only loads once this bit drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= 1'b0;
      end else if (load) begin
         pending_r <= load_bit;
      end else if (fire) begin
         pending_r <= 1'b0;
      end
   end

`ifdef DISTRIBUTE_PERF_CNT_EN
   logic [PERF_CNT_WIDTH-1:0] cnt_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (fire && (cnt_r != '1)) begin
         cnt_r <= cnt_r + 1'b1;
      end
   end

   assign o_perf_cnt = cnt_r;
`endif

endmodule

// File: rtl/distribute_1xn_one_hot_seq.sv
// Single-beat 1-to-N distributor steered by a one-hot/multicast mask.
// DISTRIBUTE_PERF_CNT_EN adds per-port delivered-beat counters (o_perf_cnt).
module distribute_1xn_one_hot_seq
   import distribute_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int NUM_DATA_OUT     = 4,
   parameter int IN_COMMAND_WIDTH = 8,
   localparam int OUT_COMMAND_WIDTH =
      (IN_COMMAND_WIDTH > NUM_DATA_OUT) ?
      (IN_COMMAND_WIDTH - NUM_DATA_OUT) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_en,
   input  logic                                 i_valid,
   input  logic [DATA_WIDTH-1:0]                i_data_bus,
   input  logic [IN_COMMAND_WIDTH-1:0]          i_cmd,
   output logic                                 o_ready,
   output logic [NUM_DATA_OUT-1:0]              o_valid,
   output logic [NUM_DATA_OUT*DATA_WIDTH-1:0]   o_data_bus,
   input  logic [NUM_DATA_OUT-1:0]              i_ready,
   output logic [OUT_COMMAND_WIDTH-1:0]         o_cmd,
   output logic                                 o_drop
`ifdef DISTRIBUTE_PERF_CNT_EN
   ,
   output logic [NUM_DATA_OUT*PERF_CNT_WIDTH-1:0] o_perf_cnt
`endif
);

   logic [DATA_WIDTH-1:0]        data_r;
   logic [OUT_COMMAND_WIDTH-1:0] cmd_r;
   logic [NUM_DATA_OUT-1:0]      pending;
   logic [NUM_DATA_OUT-1:0]      mask;
   logic                         accept;
   logic                         drop_r;
   dist_state_e                  state;

   assign mask    = i_cmd[NUM_DATA_OUT-1:0];
   assign state   = (|pending) ? BUSY : IDLE;
   assign o_ready = i_en && ((pending & ~i_ready) == '0);
   assign accept  = i_valid && o_ready;
   assign o_drop  = drop_r;
   assign o_valid = pending;
   assign o_cmd   = (state == BUSY) ? cmd_r : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= '0;
         drop_r <= 1'b0;
      end else begin
         drop_r <= accept && (mask == '0);
         if (accept) begin
            data_r <= i_data_bus;
         end
      end
   end

   generate
      if (IN_COMMAND_WIDTH > NUM_DATA_OUT) begin : g_cmd
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cmd_r <= '0;
            end else if (accept) begin
               cmd_r <= i_cmd[IN_COMMAND_WIDTH-1:NUM_DATA_OUT];
            end
         end
      end else begin : g_no_cmd
         assign cmd_r = '0;
      end
   endgenerate

   generate
      for (genvar k = 0; k < NUM_DATA_OUT; k++) begin : g_slot
         distribute_out_slot #(
            .DATA_WIDTH (DATA_WIDTH)
         ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (accept),
            .load_bit (mask[k]),
            .i_ready  (i_ready[k]),
            .data_r   (data_r),
            .o_valid  (pending[k]),
            .o_data   (o_data_bus[k*DATA_WIDTH+:DATA_WIDTH])
`ifdef DISTRIBUTE_PERF_CNT_EN
            ,
            .o_perf_cnt
               (o_perf_cnt[k*PERF_CNT_WIDTH+:PERF_CNT_WIDTH])
`endif
         );
      end
   endgenerate

endmodule

// File: tb/tb_distribute_1xn_one_hot_seq.sv
// Self-checking bench for distribute_1xn_one_hot_seq.
// Compares against a beat-level reference model of the distributor.
module tb_distribute_1xn_one_hot_seq;

   localparam int DW = 32;
   localparam int N  = 4;
   localparam int CW = 8;
   localparam int PW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            i_en;
   logic            i_valid;
   logic [DW-1:0]   i_data_bus;
   logic [CW-1:0]   i_cmd;
   logic            o_ready;
   logic [N-1:0]    o_valid;
   logic [N*DW-1:0] o_data_bus;
   logic [N-1:0]    i_ready;
   logic [CW-N-1:0] o_cmd;
   logic            o_drop;
`ifdef DISTRIBUTE_PERF_CNT_EN
   logic [N*PW-1:0] o_perf_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // reference model: the held beat and which ports still owe it
   logic [N-1:0]    m_pend;
   logic [DW-1:0]   m_data;
   logic [CW-N-1:0] m_cmd;
   logic            m_drop;
   logic            m_ready;
   int unsigned     m_cnt [N];

   always #5 clk = ~clk;

   distribute_1xn_one_hot_seq #(
      .DATA_WIDTH       (DW),
      .NUM_DATA_OUT     (N),
      .IN_COMMAND_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (i_en),
      .i_valid    (i_valid),
      .i_data_bus (i_data_bus),
      .i_cmd      (i_cmd),
      .o_ready    (o_ready),
      .o_valid    (o_valid),
      .o_data_bus (o_data_bus),
      .i_ready    (i_ready),
      .o_cmd      (o_cmd),
      .o_drop     (o_drop)
`ifdef DISTRIBUTE_PERF_CNT_EN
      ,
      .o_perf_cnt (o_perf_cnt)
`endif
   );

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_pend = '0;
      m_data = '0;
      m_cmd  = '0;
      m_drop = 1'b0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
   endtask

   task automatic check_outs();
      logic [N*DW-1:0] exp_bus;
      exp_bus = '0;
      for (int k = 0; k < N; k++)
         if (m_pend[k]) exp_bus[k*DW+:DW] = m_data;
      chk("valid", 128'(o_valid), 128'(m_pend));
      chk("data", 128'(o_data_bus), 128'(exp_bus));
      chk("cmd", 128'(o_cmd),
          128'((m_pend != 0) ? m_cmd : '0));
      chk("drop", 128'(o_drop), 128'(m_drop));
`ifdef DISTRIBUTE_PERF_CNT_EN
      for (int k = 0; k < N; k++)
         chk("perf", 128'(o_perf_cnt[k*PW+:PW]),
             128'(m_cnt[k]));
`endif
   endtask

   task automatic step(input logic v,
                       input logic [DW-1:0] d,
                       input logic [CW-1:0] c,
                       input logic [N-1:0] r,
                       input logic e);
      logic acc;
      @(negedge clk);
      check_outs();
      i_valid    = v;
      i_data_bus = d;
      i_cmd      = c;
      i_ready    = r;
      i_en       = e;
      #1;
      m_ready = e && ((m_pend & ~r) == 0);
      chk("ready", 128'(o_ready), 128'(m_ready));
      @(posedge clk);
      acc = v && m_ready;
      for (int k = 0; k < N; k++)
         if (m_pend[k] && r[k] && m_cnt[k] != 32'hFFFF)
            m_cnt[k]++;
      m_pend = m_pend & ~r;
      m_drop = acc && (c[N-1:0] == 0);
      if (acc) begin
         m_pend = c[N-1:0];
         m_data = d;
         m_cmd  = c[CW-1:N];
      end
   endtask

   initial begin
      rst_n = 1'b0;
      i_en = 1'b0;
      i_valid = 1'b0;
      i_data_bus = '0;
      i_cmd = '0;
      i_ready = '0;
      model_clear();
      @(negedge clk);
      check_outs();
      chk("rst_ready", 128'(o_ready), 128'(0));
      rst_n = 1'b1;

      // unicast
      step(1, 32'h11111111, 8'h02, 4'hF, 1);
      step(0, 32'h0, 8'h00, 4'hF, 1);
      // multicast with port0 held off
      step(1, 32'hA5A5A5A5, 8'h5F, 4'hE, 1);
      step(0, 32'h0, 8'h00, 4'hE, 1);
      step(0, 32'h0, 8'h00, 4'hE, 1);
      step(0, 32'h0, 8'h00, 4'hF, 1);
      // back-to-back unicast, no bubble
      step(1, 32'h00000001, 8'h01, 4'hF, 1);
      step(1, 32'h00000002, 8'h02, 4'hF, 1);
      step(1, 32'h00000003, 8'h04, 4'hF, 1);
      step(1, 32'h00000004, 8'h01, 4'hF, 1);
      step(0, 32'h0, 8'h00, 4'hF, 1);
      // empty mask is dropped
      step(1, 32'hDEADBEEF, 8'h30, 4'hF, 1);
      step(0, 32'h0, 8'h00, 4'hF, 1);
      // enable low blocks accept but not draining
      step(1, 32'h12345678, 8'h28, 4'h0, 1);
      step(1, 32'h87654321, 8'h01, 4'hF, 0);
      step(0, 32'h0, 8'h00, 4'hF, 1);
      // three beats to port2
      for (int i = 0; i < 3; i++)
         step(1, 32'hC0DE0000 + 32'(i), 8'h04, 4'hF, 1);
      step(0, 32'h0, 8'h00, 4'hF, 1);

      // reset mid-flight
      step(1, 32'hBAADF00D, 8'h1F, 4'h0, 1);
      step(0, 32'h0, 8'h00, 4'h0, 1);
      @(negedge clk);
      check_outs();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_data", 128'(o_data_bus), 128'(0));
      chk("rst_cmd", 128'(o_cmd), 128'(0));
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 32'h0, 8'h00, 4'hF, 1);

      for (int i = 0; i < 300; i++) begin
         logic [CW-1:0] c;
         c = 8'($urandom);
         if ($urandom_range(0, 7) == 0) c[N-1:0] = '0;
         step(1'($urandom), $urandom, c,
              4'($urandom), ($urandom_range(0, 5) != 0));
      end
      @(negedge clk);
      check_outs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
